// File: rtl/nios_basic_gpio.sv
// nios_basic_gpio: parametrised Avalon-MM GPIO slave.
//   Per-bit direction, atomic set/clear of outputs, synchronised inputs with
//   edge capture (W1C) and a maskable, registered, level-sensitive IRQ.
// Ports:
//   clk, reset          single clock domain, synchronous active-high reset
//   address[2:0]        word register select (0 DATA,1 DIR,2 MASK,3 EDGE,
//                       4 OUTSET,5 OUTCLR,6/7 reserved)
//   chipselect,write_n  write strobe = chipselect & ~write_n
//   writedata[31:0]     write data, low WIDTH bits used
//   readdata[31:0]      combinational read data, unused bits read 0
//   in_port[WIDTH]      asynchronous pad inputs
//   out_port[WIDTH]     output data register
//   oe[WIDTH]           direction register (1 = output)
//   irq                 registered level interrupt
module nios_basic_gpio #(
  parameter int unsigned            WIDTH       = 4,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0,
  parameter int unsigned            EDGE_TYPE   = 0,
  parameter int unsigned            SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_DIR    = 3'd1,
    REG_MASK   = 3'd2,
    REG_EDGE   = 3'd3,
    REG_OUTSET = 3'd4,
    REG_OUTCLR = 3'd5
  } reg_addr_e;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic             r_irq;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_in_sync;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rd;
  logic             w_unused_wd;

  assign w_wr        = chipselect & ~write_n;
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_unused_wd = ^writedata;
  assign w_in_sync   = r_sync[SYNC_STAGES-1];
  assign w_clr       = (w_wr && address == REG_EDGE) ? w_wd : '0;

  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = w_in_sync & ~r_prev;
      1:       w_edge = ~w_in_sync & r_prev;
      default: w_edge = w_in_sync ^ r_prev;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= RESET_VALUE;
      r_dir      <= '0;
      r_mask     <= '0;
      r_edge_cap <= '0;
      r_prev     <= '0;
      r_irq      <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_in_sync;
      // New edge is OR'ed in after the clear so a same-cycle edge survives W1C.
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
      // irq sees register values from before this edge: one cycle behind.
      r_irq <= |(r_edge_cap & r_mask);
      if (w_wr) begin
        case (address)
          REG_DATA:   r_data_out <= w_wd;
          REG_DIR:    r_dir      <= w_wd;
          REG_MASK:   r_mask     <= w_wd;
          REG_OUTSET: r_data_out <= r_data_out | w_wd;
          REG_OUTCLR: r_data_out <= r_data_out & ~w_wd;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      REG_DATA: w_rd = (r_dir & r_data_out) | (~r_dir & w_in_sync);
      REG_DIR:  w_rd = r_dir;
      REG_MASK: w_rd = r_mask;
      REG_EDGE: w_rd = r_edge_cap;
      default:  w_rd = '0;
    endcase
  end

  always_comb begin
    readdata = '0;
    readdata[WIDTH-1:0] = w_rd;
  end

  assign out_port = r_data_out;
  assign oe       = r_dir;
  assign irq      = r_irq;

endmodule

// File: tb/tb_nios_basic_gpio.sv
// Directed self-checking bench for nios_basic_gpio (WIDTH=8, RESET_VALUE=A5,
// rising-edge capture, 2-stage synchroniser).
module tb_nios_basic_gpio;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  in_port = '0;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  nios_basic_gpio #(
    .WIDTH(8),
    .RESET_VALUE(8'hA5),
    .EDGE_TYPE(0),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    in_port = '0;
    do_reset();
    n_cmp++; if (out_port !== 8'hA5) begin n_err++; $display("FAIL reset_out_port got=%h exp=a5", out_port); end
    n_cmp++; if (oe !== 8'h00) begin n_err++; $display("FAIL reset_oe got=%h exp=00", oe); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rd(3'd3, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_edge got=%h exp=0", d); end
    rd(3'd2, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mask got=%h exp=0", d); end
  endtask

  task automatic test_set_clear();
    logic [31:0] d;
    do_write(3'd0, 32'h0F);
    n_cmp++; if (out_port !== 8'h0F) begin n_err++; $display("FAIL data_write got=%h exp=0f", out_port); end
    do_write(3'd4, 32'hF0);
    n_cmp++; if (out_port !== 8'hFF) begin n_err++; $display("FAIL outset got=%h exp=ff", out_port); end
    do_write(3'd5, 32'h3C);
    n_cmp++; if (out_port !== 8'hC3) begin n_err++; $display("FAIL outclr got=%h exp=c3", out_port); end
    do_write(3'd1, 32'hFF);
    n_cmp++; if (oe !== 8'hFF) begin n_err++; $display("FAIL dir_oe got=%h exp=ff", oe); end
    rd(3'd0, d);
    n_cmp++; if (d !== 32'hC3) begin n_err++; $display("FAIL data_read_out got=%h exp=c3", d); end
    // upper writedata bits must not leak into an 8-bit register
    do_write(3'd2, 32'hFFFF_FF00);
    rd(3'd2, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mask_width got=%h exp=0", d); end
  endtask

  task automatic test_rising_edge();
    logic [31:0] d;
    do_reset();
    do_write(3'd2, 32'h01);
    @(negedge clk);
    in_port = 8'h01;
    tick();
    tick();
    rd(3'd3, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL edge_early got=%h exp=0", d); end
    rd(3'd0, d);
    n_cmp++; if (d !== 32'h01) begin n_err++; $display("FAIL in_sync_read got=%h exp=01", d); end
    tick();
    rd(3'd3, d);
    n_cmp++; if (d !== 32'h01) begin n_err++; $display("FAIL edge_cap got=%h exp=01", d); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early got=%b exp=0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set got=%b exp=1", irq); end
    @(negedge clk);
    in_port = 8'h03;
    tick(); tick(); tick();
    rd(3'd3, d);
    n_cmp++; if (d !== 32'h03) begin n_err++; $display("FAIL edge_bit1 got=%h exp=03", d); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_unmasked got=%b exp=1", irq); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    // falling edge on bit0 is not captured in rising mode
    @(negedge clk);
    in_port = 8'h02;
    tick(); tick(); tick(); tick();
    rd(3'd3, d);
    n_cmp++; if (d !== 32'h03) begin n_err++; $display("FAIL fall_ignored got=%h exp=03", d); end
    @(negedge clk);
    in_port = 8'h03;
    tick(); tick();
    do_write(3'd3, 32'h01);
    rd(3'd3, d);
    n_cmp++; if (d !== 32'h03) begin n_err++; $display("FAIL w1c_race got=%h exp=03", d); end
    do_write(3'd3, 32'h03);
    rd(3'd3, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL w1c_clear got=%h exp=0", d); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_lag got=%b exp=1", irq); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear got=%b exp=0", irq); end
  endtask

  task automatic test_mask_irq();
    logic [31:0] d;
    do_write(3'd2, 32'h00);
    @(negedge clk);
    in_port = 8'h00;
    tick(); tick();
    @(negedge clk);
    in_port = 8'h01;
    tick(); tick(); tick(); tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_masked got=%b exp=0", irq); end
    do_write(3'd2, 32'h01);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mask_lag got=%b exp=0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL mask_irq got=%b exp=1", irq); end
  endtask

  task automatic test_direction_mux();
    logic [31:0] d;
    do_reset();
    do_write(3'd1, 32'h0F);
    do_write(3'd0, 32'hAA);
    @(negedge clk);
    in_port = 8'h55;
    tick(); tick();
    rd(3'd0, d);
    n_cmp++; if (d !== 32'h5A) begin n_err++; $display("FAIL dir_mux got=%h exp=5a", d); end
    rd(3'd1, d);
    n_cmp++; if (d !== 32'h0F) begin n_err++; $display("FAIL dir_read got=%h exp=0f", d); end
    do_write(3'd6, 32'hFF);
    do_write(3'd7, 32'hFF);
    n_cmp++; if (out_port !== 8'hAA || oe !== 8'h0F) begin
      n_err++; $display("FAIL reserved_write got=%h/%h exp=aa/0f", out_port, oe);
    end
    for (int a = 4; a < 8; a++) begin
      rd(3'(a), d);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL read_zero_%0d got=%h exp=0", a, d); end
    end
  endtask

  task automatic test_midop_reset();
    logic [31:0] d;
    do_write(3'd2, 32'h01);
    @(negedge clk);
    in_port = 8'h00;
    tick(); tick();
    @(negedge clk);
    in_port = 8'h01;
    tick(); tick(); tick(); tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
    @(negedge clk);
    reset = 1'b1;
    address = 3'd0; writedata = 32'h3C; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    n_cmp++; if (out_port !== 8'hA5 || oe !== 8'h00 || irq !== 1'b0) begin
      n_err++; $display("FAIL midop_reset got=%h/%h/%b exp=a5/00/0", out_port, oe, irq);
    end
    rd(3'd3, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL midop_edge got=%h exp=0", d); end
    // in_port[0] stays high across reset release
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    rd(3'd3, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL post_reset_early got=%h exp=0", d); end
    tick();
    rd(3'd3, d);
    n_cmp++; if (d !== 32'h01) begin n_err++; $display("FAIL post_reset_edge got=%h exp=01", d); end
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_rising_edge();
    test_w1c_race();
    test_mask_irq();
    test_direction_mux();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
